// File: rtl/id_regfile_dump_ctrl_pkg.sv
// Shared types and defaults for the ID-stage register-file dump controller.
// Default widths plus the dump FSM state encoding.
package id_regfile_dump_ctrl_pkg;
    localparam int NB_DATA_DEF      = 32;
    localparam int NB_REG_DEF       = 5;
    localparam int SIZE_REG_DEF     = 32;
    localparam int DRAIN_CYCLES_DEF = 3;
    localparam int NB_DRAIN_DEF     = 2;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        DRAIN = 2'd1,
        DUMP  = 2'd2,
        DONE  = 2'd3
    } dump_state_e;

    // Debug writes only reach the write port when writeback is quiet and no dump is running.
    function automatic logic dbg_write_wins(logic wb_write, logic dbg_write, dump_state_e st);
        return !wb_write && dbg_write && (st == IDLE);
    endfunction
endpackage

// File: rtl/id_regfile_dump_ctrl_dump_counter.sv
// Drain countdown and dump index for the register-file dump controller.
// drain_zero and idx_last are the terminal flags the FSM branches on.
module id_dump_counter #(
    parameter int NB_REG       = 5,
    parameter int SIZE_REG     = 32,
    parameter int DRAIN_CYCLES = 3,
    parameter int NB_DRAIN     = 2
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              drain_load,
    input  logic              drain_dec,
    input  logic              idx_inc,
    input  logic              idx_clr,
    output logic              drain_zero,
    output logic [NB_REG-1:0] idx,
    output logic              idx_last
);
    logic [NB_DRAIN-1:0] drain_cnt;

    assign drain_zero = (drain_cnt == '0);
    assign idx_last   = (idx == NB_REG'(SIZE_REG - 1));

    always_ff @(posedge clk) begin
        if (reset) begin
            drain_cnt <= '0;
            idx       <= '0;
        end else begin
            if (drain_load)
                drain_cnt <= NB_DRAIN'(DRAIN_CYCLES - 1);
            else if (drain_dec && !drain_zero)
                drain_cnt <= drain_cnt - 1'b1;

            // The last accepted word wraps the index back to 0 for the next dump.
            if (idx_clr)
                idx <= '0;
            else if (idx_inc)
                idx <= idx_last ? '0 : idx + 1'b1;
        end
    end
endmodule

// File: rtl/id_regfile_dump_ctrl.sv
// Owns the register-file write port and read port 1: arbitrates writeback vs debug
// writes, and on request stalls, drains, then streams every register to the debug unit.
module id_regfile_dump_ctrl
    import id_regfile_dump_ctrl_pkg::*;
#(
    parameter int NB_DATA      = NB_DATA_DEF,
    parameter int NB_REG       = NB_REG_DEF,
    parameter int SIZE_REG     = SIZE_REG_DEF,
    parameter int DRAIN_CYCLES = DRAIN_CYCLES_DEF,
    parameter int NB_DRAIN     = NB_DRAIN_DEF
) (
    input  logic               i_clk,
    input  logic               i_reset,
    input  logic               i_wb_write,
    input  logic [NB_REG-1:0]  i_wb_addr,
    input  logic [NB_DATA-1:0] i_wb_data,
    input  logic               i_dbg_write,
    input  logic [NB_REG-1:0]  i_dbg_addr,
    input  logic [NB_DATA-1:0] i_dbg_data,
    output logic               o_dbg_wr_grant,
    input  logic               i_dbg_dump_req,
    input  logic               i_dbg_ready,
    output logic               o_dbg_valid,
    output logic [NB_REG-1:0]  o_dbg_addr,
    output logic [NB_DATA-1:0] o_dbg_data,
    output logic               o_dbg_done,
    output logic               o_stall,
    input  logic [NB_REG-1:0]  i_rs,
    output logic [NB_REG-1:0]  o_rf_raddr,
    input  logic [NB_DATA-1:0] i_rf_rdata,
    output logic               o_rf_write,
    output logic [NB_REG-1:0]  o_rf_waddr,
    output logic [NB_DATA-1:0] o_rf_wdata
);
    dump_state_e       state;
    logic              drain_zero;
    logic              idx_last;
    logic [NB_REG-1:0] idx;
    logic              handshake;

    assign handshake = o_dbg_valid && i_dbg_ready;

    id_dump_counter #(
        .NB_REG       (NB_REG),
        .SIZE_REG     (SIZE_REG),
        .DRAIN_CYCLES (DRAIN_CYCLES),
        .NB_DRAIN     (NB_DRAIN)
    ) u_cnt (
        .clk        (i_clk),
        .reset      (i_reset),
        .drain_load ((state == IDLE) && i_dbg_dump_req),
        .drain_dec  (state == DRAIN),
        .idx_inc    (handshake),
        .idx_clr    (state == DRAIN),
        .drain_zero (drain_zero),
        .idx        (idx),
        .idx_last   (idx_last)
    );

    assign o_dbg_wr_grant = dbg_write_wins(i_wb_write, i_dbg_write, state);

    always_comb begin
        o_rf_write = 1'b0;
        o_rf_waddr = i_wb_addr;
        o_rf_wdata = i_wb_data;
        if (i_wb_write) begin
            o_rf_write = 1'b1;
        end else if (o_dbg_wr_grant) begin
            o_rf_write = 1'b1;
            o_rf_waddr = i_dbg_addr;
            o_rf_wdata = i_dbg_data;
        end
    end

    // During the dump read port 1 is stolen from the decoder; the stall keeps ID from using it.
    assign o_rf_raddr = (state == DUMP) ? idx : i_rs;
    assign o_dbg_addr = idx;
    assign o_dbg_data = i_rf_rdata;

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            state       <= IDLE;
            o_stall     <= 1'b0;
            o_dbg_valid <= 1'b0;
            o_dbg_done  <= 1'b0;
        end else begin
            case (state)
                IDLE: if (i_dbg_dump_req) begin
                    state   <= DRAIN;
                    o_stall <= 1'b1;
                end
                DRAIN: if (drain_zero) begin
                    state       <= DUMP;
                    o_dbg_valid <= 1'b1;
                end
                DUMP: if (handshake && idx_last) begin
                    state       <= DONE;
                    o_dbg_valid <= 1'b0;
                    o_dbg_done  <= 1'b1;
                end
                DONE: begin
                    state      <= IDLE;
                    o_dbg_done <= 1'b0;
                    o_stall    <= 1'b0;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule
